hellorld_rx: RTL and testbench
==============================

# hellorld_rx

UART 8N1 receiver placed directly downstream of the hellorld transmitter. It deserialises the `io_out` stream, using the same 12-bit baud setting, into bytes held in a small FIFO with a valid/ready output. On-chip loopback and bring-up use it to check the "Hellorld!\r\n" stream without an external analyser. Framing and overrun errors are reported as sticky flags.

## Interface
Parameters:
- `FIFO_DEPTH`, 4: receive FIFO entries; power of two, at least 2.
- `SYNC_STAGES`, 2: flops in the `rx_in` synchroniser; at least 2.

Ports:
- `wb_clk_i` in 1: the single clock.
- `wb_rst_i` in 1: reset, asynchronous and active-high.
- `rx_in` in 1: asynchronous serial input; idles high.
- `baud_div` in 12: bit period is `baud_div+1` clocks. The value must be at least 7; behaviour below 7 is unspecified.
- `m_data` out 8: byte at the FIFO head.
- `m_valid` out 1: FIFO not empty.
- `m_ready` in 1: consumer accepts `m_data` in any cycle where `m_valid && m_ready`.
- `busy` out 1: high in every state except IDLE.
- `frame_err` out 1: sticky framing-error flag.
- `overrun` out 1: sticky flag for a byte dropped because the FIFO was full.
- `clr_flags` in 1: synchronous clear of both sticky flags.

## Operation
Input conditioning:
- `rx_in` passes through `SYNC_STAGES` flops; the last flop is `rx_s`.
- Synchroniser flops reset to 1, so reset never produces a false start.

Counters:
- `cnt` is 12 bits, counts up by 1 per clock, and is cleared as described per state.
- `h = baud_div >> 1`.
- `bit_idx` is 3 bits.

FSM states:
- IDLE: if `rx_s==0`, then `cnt<=0` and go to START.
- START: when `cnt==h`:
  - `rx_s==0`: `cnt<=0`, `bit_idx<=0`, go to DATA.
  - Otherwise: glitch; go to IDLE with no flag.
- DATA: when `cnt==baud_div`:
  - Shift right: `shreg <= {rx_s, shreg[7:1]}` (LSB first).
  - `cnt<=0`.
  - After the 8th sample (`bit_idx==7`) go to STOP; otherwise `bit_idx+1`.
- STOP: when `cnt==baud_div`:
  - `rx_s==1`: push `shreg` to the FIFO and go to IDLE.
  - `rx_s==0`: set `frame_err`, discard the byte, go to BREAK.
- BREAK: wait for `rx_s==1`, then go to IDLE. A held-low line therefore cannot retrigger a start.

FIFO:
- Pop happens when `m_valid && m_ready`.
- Push while full with a simultaneous pop is accepted.
- Push while full without a pop drops the new byte, sets `overrun`, and leaves the FIFO contents unchanged.
- `m_data` is the registered head entry. It is stable while `m_valid && !m_ready`.

Flags:
- Set by the events above and cleared by `clr_flags`.
- If a set and `clr_flags` occur in the same cycle, set wins.

Baud changes:
- A change to `baud_div` mid-frame takes effect immediately.
- That frame's content is undefined, but the FSM must still return to IDLE.

## Timing
Reset values:
- State IDLE, `busy=0`, `m_valid=0`, `m_data=0`, `frame_err=0`, `overrun=0`.
- FIFO empty, all counters 0.

Sampling schedule (E = edge at which IDLE first sees `rx_s==0`):
- Start bit is validated at edge E+1+h.
- Data bit k (k=1..8) is sampled at E+1+h+k·(`baud_div`+1).
- Stop bit is sampled at E+1+h+9·(`baud_div`+1).

Latency and handshake:
- `m_valid` rises one clock after the stop sample when the FIFO was empty.
- Pin-to-`rx_s` latency is `SYNC_STAGES` clocks.
- Pop takes effect at the accepting edge; the next entry, or `m_valid=0`, appears in the following cycle.

Back-to-back frames:
- A new start bit may immediately follow the stop sample; IDLE must be able to leave in the very next cycle.

Reset mid-frame:
- Asynchronous reset mid-frame aborts the frame and empties the FIFO.
- The receiver is ready for a new start as soon as reset deasserts and `rx_s` has seen a high level.

## Test plan
- `baud_div=15`; drive 0x48 as 8N1 at 16 clocks/bit. Required: `m_data=0x48`, with `m_valid` rising exactly at E+2+7+144, and no flags set.
- Loop back a hellorld transmitter with `custom_settings=baud_div=20` and hold `m_ready=1`. Required: the byte sequence 0x48 65 6C 6C 6F 72 6C 64 21 0D 0A repeats with zero flags.
- Drive a 4-clock low glitch on `rx_in` with `baud_div=15`. Required: FSM returns to IDLE, no push, no flag.
- Send a frame with the stop bit 0 and hold the line low for 40 clocks. Required: `frame_err=1`, no push, `busy` high until the line goes high, then a correct next byte.
- With `m_ready=0`, send bytes 0x01..0x05 (`FIFO_DEPTH=4`). Required: `overrun=1`; draining yields 0x01..0x04 in order. `clr_flags` together with a new overrun leaves `overrun=1`.
- Assert `wb_rst_i` during data bit 4. Required: all outputs return to reset values immediately; the next full frame is received correctly.

Source files
------------

// File: rtl/hellorld_rx.sv
// UART 8N1 receiver for the hellorld stream: deserialises rx_in into a small
// FIFO with valid/ready output and sticky framing/overrun flags.
module hellorld_rx #(
    parameter int FIFO_DEPTH  = 4,
    parameter int SYNC_STAGES = 2
) (
    input  logic        wb_clk_i,
    input  logic        wb_rst_i,
    input  logic        rx_in,
    input  logic [11:0] baud_div,
    output logic [7:0]  m_data,
    output logic        m_valid,
    input  logic        m_ready,
    output logic        busy,
    output logic        frame_err,
    output logic        overrun,
    input  logic        clr_flags
);

    localparam int AW = $clog2(FIFO_DEPTH);
    localparam int CW = AW + 1;
    localparam logic [CW-1:0] FULL_CNT = CW'(FIFO_DEPTH);

    typedef enum logic [2:0] {
        S_IDLE,
        S_START,
        S_DATA,
        S_STOP,
        S_BREAK
    } state_e;

    logic [SYNC_STAGES-1:0] sync_q;
    logic                   rx_s;

    state_e      state_q, state_d;
    logic [11:0] cnt_q, cnt_d;
    logic [2:0]  bit_q, bit_d;
    logic [7:0]  shreg_q, shreg_d;
    logic        push_q, push_d;
    logic [7:0]  pdata_q, pdata_d;
    logic        ferr_q, ferr_d;
    logic        ovr_q, ovr_d;
    logic        ferr_set;
    logic [11:0] half;

    logic [7:0]    mem_q [FIFO_DEPTH];
    logic [AW-1:0] wr_q, rd_q;
    logic [CW-1:0] count_q;
    logic          pop, full, wr_en, ovr_set;

    // Synchroniser resets high so a reset never looks like a start bit.
    always_ff @(posedge wb_clk_i or posedge wb_rst_i) begin
        if (wb_rst_i) begin
            sync_q <= '1;
        end else begin
            sync_q <= {sync_q[SYNC_STAGES-2:0], rx_in};
        end
    end

    assign rx_s = sync_q[SYNC_STAGES-1];
    assign half = {1'b0, baud_div[11:1]};

    always_ff @(posedge wb_clk_i or posedge wb_rst_i) begin
        if (wb_rst_i) begin
            state_q <= S_IDLE;
            cnt_q   <= '0;
            bit_q   <= '0;
            shreg_q <= '0;
            push_q  <= 1'b0;
            pdata_q <= '0;
            ferr_q  <= 1'b0;
            ovr_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            bit_q   <= bit_d;
            shreg_q <= shreg_d;
            push_q  <= push_d;
            pdata_q <= pdata_d;
            ferr_q  <= ferr_d;
            ovr_q   <= ovr_d;
        end
    end

    // Magnitude compares keep a mid-frame baud reduction from stalling.
    always_comb begin
        state_d  = state_q;
        cnt_d    = cnt_q + 12'd1;
        bit_d    = bit_q;
        shreg_d  = shreg_q;
        push_d   = 1'b0;
        pdata_d  = pdata_q;
        ferr_set = 1'b0;
        unique case (state_q)
            S_IDLE: begin
                if (!rx_s) begin
                    cnt_d   = '0;
                    state_d = S_START;
                end
            end
            S_START: begin
                if (cnt_q >= half) begin
                    if (!rx_s) begin
                        cnt_d   = '0;
                        bit_d   = '0;
                        state_d = S_DATA;
                    end else begin
                        state_d = S_IDLE;
                    end
                end
            end
            S_DATA: begin
                if (cnt_q >= baud_div) begin
                    shreg_d = {rx_s, shreg_q[7:1]};
                    cnt_d   = '0;
                    if (bit_q == 3'd7) begin
                        state_d = S_STOP;
                    end else begin
                        bit_d = bit_q + 3'd1;
                    end
                end
            end
            S_STOP: begin
                if (cnt_q >= baud_div) begin
                    cnt_d = '0;
                    if (rx_s) begin
                        push_d  = 1'b1;
                        pdata_d = shreg_q;
                        state_d = S_IDLE;
                    end else begin
                        ferr_set = 1'b1;
                        state_d  = S_BREAK;
                    end
                end
            end
            S_BREAK: begin
                if (rx_s) begin
                    state_d = S_IDLE;
                end
            end
            default: state_d = S_IDLE;
        endcase
    end

    assign pop     = m_valid && m_ready;
    assign full    = (count_q == FULL_CNT);
    assign wr_en   = push_q && (!full || pop);
    assign ovr_set = push_q && full && !pop;

    assign ferr_d = ferr_set | (ferr_q & ~clr_flags);
    assign ovr_d  = ovr_set | (ovr_q & ~clr_flags);

    always_ff @(posedge wb_clk_i or posedge wb_rst_i) begin
        if (wb_rst_i) begin
            for (int i = 0; i < FIFO_DEPTH; i++) begin
                mem_q[i] <= '0;
            end
        end else if (wr_en) begin
            mem_q[wr_q] <= pdata_q;
        end
    end

    always_ff @(posedge wb_clk_i or posedge wb_rst_i) begin
        if (wb_rst_i) begin
            wr_q    <= '0;
            rd_q    <= '0;
            count_q <= '0;
        end else begin
            if (wr_en) begin
                wr_q <= wr_q + AW'(1);
            end
            if (pop) begin
                rd_q <= rd_q + AW'(1);
            end
            if (wr_en && !pop) begin
                count_q <= count_q + CW'(1);
            end else if (!wr_en && pop) begin
                count_q <= count_q - CW'(1);
            end
        end
    end

    assign m_data    = mem_q[rd_q];
    assign m_valid   = (count_q != '0);
    assign busy      = (state_q != S_IDLE);
    assign frame_err = ferr_q;
    assign overrun   = ovr_q;

endmodule

// File: tb/tb_hellorld_rx.sv
// Directed plus randomized bench for hellorld_rx against a byte-queue model.
module tb_hellorld_rx;

    logic        clk = 1'b0;
    logic        rst;
    logic        rx_in;
    logic [11:0] baud;
    logic [7:0]  m_data;
    logic        m_valid;
    logic        m_ready;
    logic        busy;
    logic        frame_err;
    logic        overrun;
    logic        clr;

    logic man_ready = 1'b0;
    logic rnd_en = 1'b0;
    logic rnd_bit = 1'b0;

    int nerr = 0;
    int nchk = 0;
    int cyc = 0;
    int rise_cyc = -1;
    logic prev_v = 1'b0;

    logic [7:0] exp_q[$];
    logic [7:0] hel[11];

    assign m_ready = rnd_en ? rnd_bit : man_ready;

    hellorld_rx #(.FIFO_DEPTH(4), .SYNC_STAGES(2)) dut (
        .wb_clk_i (clk),
        .wb_rst_i (rst),
        .rx_in    (rx_in),
        .baud_div (baud),
        .m_data   (m_data),
        .m_valid  (m_valid),
        .m_ready  (m_ready),
        .busy     (busy),
        .frame_err(frame_err),
        .overrun  (overrun),
        .clr_flags(clr)
    );

    always #5 clk = ~clk;

    always @(posedge clk) begin
        cyc     <= cyc + 1;
        rnd_bit <= 1'($urandom_range(0, 1));
    end

    task automatic check(string tag, logic [31:0] obs, logic [31:0] exp);
        nchk++;
        assert (obs === exp) else begin
            nerr++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // Consumer side: every accepted byte must be the next one the model expects.
    always @(negedge clk) begin
        if (m_valid && !prev_v) rise_cyc = cyc;
        prev_v = m_valid;
        if (!rst && m_valid && m_ready) begin
            if (exp_q.size() == 0) begin
                nchk++;
                assert (exp_q.size() != 0) else begin
                    nerr++;
                    $error("FAIL rx_extra observed=%0h expected=none", m_data);
                end
            end else begin
                check("rx_byte", {24'd0, m_data}, {24'd0, exp_q.pop_front()});
            end
        end
    end

    task automatic cycles(int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic send(logic [7:0] b, logic stop, int bd);
        logic [9:0] fr;
        fr = {stop, b, 1'b0};
        for (int i = 0; i < 10; i++) begin
            rx_in = fr[i];
            repeat (bd + 1) @(posedge clk);
            #1;
        end
    endtask

    task automatic pulse_clr();
        clr = 1'b1;
        cycles(1);
        clr = 1'b0;
    endtask

    initial begin
        int c0;
        int bd;
        logic [7:0] b;
        logic bad;

        hel = '{8'h48, 8'h65, 8'h6C, 8'h6C, 8'h6F, 8'h72,
                8'h6C, 8'h64, 8'h21, 8'h0D, 8'h0A};
        rst   = 1'b1;
        rx_in = 1'b1;
        clr   = 1'b0;
        baud  = 12'd15;
        cycles(3);
        check("rst_valid", {31'd0, m_valid}, 0);
        check("rst_data", {24'd0, m_data}, 0);
        check("rst_busy", {31'd0, busy}, 0);
        check("rst_ferr", {31'd0, frame_err}, 0);
        check("rst_ovr", {31'd0, overrun}, 0);
        rst = 1'b0;
        cycles(5);

        // 0x48 at 16 clocks/bit with exact m_valid timing
        c0 = cyc;
        rise_cyc = -1;
        exp_q.push_back(8'h48);
        send(8'h48, 1'b1, 15);
        cycles(10);
        check("rise_time", rise_cyc, c0 + 2 + 1 + 2 + 7 + 9 * 16);
        check("h48_data", {24'd0, m_data}, 32'h48);
        check("h48_ferr", {31'd0, frame_err}, 0);
        check("h48_ovr", {31'd0, overrun}, 0);
        man_ready = 1'b1;
        cycles(3);
        check("h48_drain", {31'd0, m_valid}, 0);

        // back-to-back hellorld stream at baud_div=20
        baud = 12'd20;
        for (int r = 0; r < 2; r++) begin
            for (int i = 0; i < 11; i++) begin
                exp_q.push_back(hel[i]);
                send(hel[i], 1'b1, 20);
            end
        end
        cycles(30);
        check("hel_left", exp_q.size(), 0);
        check("hel_ferr", {31'd0, frame_err}, 0);
        check("hel_ovr", {31'd0, overrun}, 0);

        // random bytes, baud rates, gaps and occasional bad stop bits
        rnd_en = 1'b1;
        for (int i = 0; i < 16; i++) begin
            bd   = $urandom_range(7, 30);
            baud = 12'(bd);
            b    = 8'($urandom);
            bad  = ($urandom_range(0, 4) == 0);
            if (!bad) exp_q.push_back(b);
            send(b, !bad, bd);
            if (bad) begin
                cycles(bd + 1);
                rx_in = 1'b1;
                cycles(5);
                check("rnd_ferr", {31'd0, frame_err}, 1);
                pulse_clr();
            end
            cycles($urandom_range(0, 20));
        end
        cycles(80);
        rnd_en = 1'b0;
        man_ready = 1'b1;
        cycles(5);
        check("rnd_left", exp_q.size(), 0);
        check("rnd_ferr0", {31'd0, frame_err}, 0);
        check("rnd_ovr0", {31'd0, overrun}, 0);

        // 4-clock glitch must not start a frame
        baud = 12'd15;
        cycles(5);
        rx_in = 1'b0;
        cycles(4);
        rx_in = 1'b1;
        cycles(1);
        check("glitch_busy", {31'd0, busy}, 1);
        cycles(30);
        check("glitch_idle", {31'd0, busy}, 0);
        check("glitch_valid", {31'd0, m_valid}, 0);
        check("glitch_ferr", {31'd0, frame_err}, 0);

        // framing error followed by a held-low line
        send(8'hA5, 1'b0, 15);
        cycles(40);
        check("brk_busy", {31'd0, busy}, 1);
        check("brk_ferr", {31'd0, frame_err}, 1);
        check("brk_valid", {31'd0, m_valid}, 0);
        rx_in = 1'b1;
        cycles(5);
        check("brk_idle", {31'd0, busy}, 0);
        exp_q.push_back(8'h3C);
        send(8'h3C, 1'b1, 15);
        cycles(10);
        check("brk_next", exp_q.size(), 0);
        check("brk_sticky", {31'd0, frame_err}, 1);
        pulse_clr();
        check("brk_clr", {31'd0, frame_err}, 0);

        // overrun with a stalled consumer
        man_ready = 1'b0;
        for (int v = 1; v <= 5; v++) begin
            if (v <= 4) exp_q.push_back(8'(v));
            send(8'(v), 1'b1, 15);
            cycles(3);
        end
        check("ovr_set", {31'd0, overrun}, 1);
        check("ovr_head", {24'd0, m_data}, 1);
        check("ovr_full", {31'd0, m_valid}, 1);
        man_ready = 1'b1;
        cycles(8);
        check("ovr_empty", {31'd0, m_valid}, 0);
        check("ovr_left", exp_q.size(), 0);
        man_ready = 1'b0;
        pulse_clr();
        check("ovr_clr", {31'd0, overrun}, 0);
        for (int v = 8'h11; v <= 8'h14; v++) begin
            exp_q.push_back(8'(v));
            send(8'(v), 1'b1, 15);
            cycles(3);
        end
        check("ovr_pre", {31'd0, overrun}, 0);
        // clr lands on the same edge the overrun is raised
        fork
            send(8'h15, 1'b1, 15);
            begin
                cycles(2 + 1 + 1 + 7 + 9 * 16);
                clr = 1'b1;
                cycles(1);
                clr = 1'b0;
            end
        join
        cycles(3);
        check("ovr_race", {31'd0, overrun}, 1);
        man_ready = 1'b1;
        cycles(8);
        check("ovr_left2", exp_q.size(), 0);

        // asynchronous reset during data bit 4
        man_ready = 1'b0;
        exp_q.push_back(8'h77);
        send(8'h77, 1'b1, 15);
        cycles(5);
        check("mr_valid", {31'd0, m_valid}, 1);
        fork
            send(8'hC3, 1'b1, 15);
            begin
                cycles(70);
                check("mr_busy", {31'd0, busy}, 1);
                #2 rst = 1'b1;
                #1;
                check("mr_rvalid", {31'd0, m_valid}, 0);
                check("mr_rdata", {24'd0, m_data}, 0);
                check("mr_rbusy", {31'd0, busy}, 0);
                check("mr_rovr", {31'd0, overrun}, 0);
                check("mr_rferr", {31'd0, frame_err}, 0);
            end
        join
        exp_q.delete();
        cycles(2);
        rst = 1'b0;
        cycles(5);
        exp_q.push_back(8'h5A);
        send(8'h5A, 1'b1, 15);
        man_ready = 1'b1;
        cycles(10);
        check("mr_next", exp_q.size(), 0);
        check("mr_ferr", {31'd0, frame_err}, 0);

        cycles(10);
        $display("Result: errors=%0d of %0d checks", nerr, nchk);
        $finish;
    end

endmodule
